linkinit_sb_responder: RTL and testbench
========================================

# linkinit_sb_responder

Sideband responder for the LINKINIT state of the LTSM on the partner die. It waits for the remote `LINKINIT` initiator's RDI Req.Active sideband request and returns the matching Rsp.Active message through the SB TX port. It then reports completion or failure to the local LTSM. It sits beside the LINKINIT initiator and shares the same SB TX/RX message ports and the retry-timeout service.

## Interface
Parameters:
- MAX_UNEXPECTED, 8: number of non-matching SB messages tolerated in WAIT_REQ before ERROR; range 1..15.

Ports:
- clk_100MHz  in  1  sole clock. Sideband domain.
- reset  in  1  asynchronous, active-high reset.
- enable_i  in  1  level; high while the LTSM is in LINKINIT.
- rsp_done_o  out  1  response accepted by the SB TX port.
- rsp_error_o  out  1  timeout or excess unexpected messages.
- SB_TX_msg_o  out  SB_msg_t  outgoing message code.
- SB_TX_dataBus_o  out  64  outgoing payload.
- SB_TX_msg_valid_o  out  1  TX request.
- SB_TX_msg_sendNextFlag_i  in  1  TX accept.
- SB_RX_msg_i  in  SB_msg_t  incoming message code.
- SB_RX_dataBus_i  in  64  incoming payload.
- SB_RX_msg_req_o  out  1  ready to consume an RX message.
- SB_RX_msg_valid_i  in  1  RX message present; one-cycle pulse.
- SBmessage_retry_timeout_flag  in  1  shared retry timer expired.
- reset_SBmessage_retry_timeout  out  1  one-cycle clear of the retry timer.
- reset_state_timeout_counter_o  out  1  one-cycle clear of the LTSM state timer.

## Operation
States: IDLE, WAIT_REQ, SEND_RSP, DONE, ERROR. All outputs are registered and reset to 0; SB_TX_msg_o resets to SB_NOP.

- **IDLE**
  - All outputs are 0.
  - enable_i=1 → WAIT_REQ. On this transition, pulse both timer-reset outputs for 1 cycle and clear the unexpected counter.
- **WAIT_REQ**
  - SB_RX_msg_req_o=1.
  - A message is consumed when SB_RX_msg_valid_i=1 and SB_RX_msg_req_o=1.
  - If SB_RX_msg_i==SB_LINKINIT_REQ_ACTIVE: capture SB_RX_dataBus_i into the 64-bit payload register, go to SEND_RSP, and pulse reset_SBmessage_retry_timeout.
  - Any other code increments the 4-bit unexpected counter (saturating at 15). When the counter reaches MAX_UNEXPECTED, go to ERROR.
  - SBmessage_retry_timeout_flag=1 → ERROR.
- **SEND_RSP**
  - SB_RX_msg_req_o=0.
  - SB_TX_msg_o=SB_LINKINIT_RSP_ACTIVE and SB_TX_dataBus_o=captured payload (echo) are held stable while SB_TX_msg_valid_o=1.
  - Accept condition is valid & SB_TX_msg_sendNextFlag_i. On accept → DONE.
  - Timeout flag → ERROR.
- **DONE**
  - rsp_done_o=1, held until enable_i falls.
  - TX valid=0.
- **ERROR**
  - rsp_error_o=1, held until enable_i falls.
  - TX valid=0 and RX req=0.
- **Global abort:** enable_i=0 in any state → IDLE on the next edge, with all outputs cleared. The abort has priority over every other event.

Priority rules for simultaneous events:
- Matching request and timeout in the same cycle in WAIT_REQ: the request wins.
- Accept and timeout in the same cycle in SEND_RSP: the accept wins.
- Unexpected message and timeout in the same cycle: ERROR, and the counter still increments.

## Timing
- enable_i sampled high at edge N → WAIT_REQ and timer-reset pulses visible after edge N, lasting 1 cycle.
- Matching RX message at edge M → SB_TX_msg_valid_o=1 after edge M (1-cycle latency).
- Accept at edge K → valid=0 and rsp_done_o=1 after edge K.
- Reset asserted mid-operation → all outputs 0 immediately, with no wait for the clock. State goes to IDLE.
- After reset is released, enable_i already high still requires one edge to reach WAIT_REQ.

## Configuration
- LINKINIT_RSP_DUP_EN controls duplicate-request handling.
- **Defined:**
  - In DONE, SB_RX_msg_req_o stays 1.
  - A repeated SB_LINKINIT_REQ_ACTIVE (the partner retried because the response was lost) recaptures the payload and returns to SEND_RSP.
  - rsp_done_o drops in the same cycle SEND_RSP is entered.
  - Other codes in DONE are discarded and not counted.
- **Undefined:** DONE holds SB_RX_msg_req_o=0 and ignores RX traffic.

## Structure
- SB_codex_pkg gains SB_LINKINIT_REQ_ACTIVE and SB_LINKINIT_RSP_ACTIVE in SB_msg_t, if they are not already present.
- The state enum linkinit_rsp_state_t also lives in the package for bench visibility.
- The block is a single module with no sub-module. The FSM, payload register and unexpected counter are all local.

## Test plan
- **Nominal:** enable_i=1; RX REQ_ACTIVE with data 0xDEADBEEF_00000001; sendNextFlag 3 cycles later → TX RSP_ACTIVE with the same data, valid for exactly 3 cycles, then rsp_done_o=1.
- **Unexpected flood:** MAX_UNEXPECTED=3; send 3 SB_NOP-class non-matching codes → rsp_error_o=1 after the third. A REQ sent afterwards is ignored.
- **Timeout:** enable_i=1, no RX traffic, assert the timeout flag → rsp_error_o=1 next cycle and SB_RX_msg_req_o=0.
- **Races:**
  - REQ and timeout flag in the same cycle → SEND_RSP, not ERROR.
  - Accept and timeout in the same cycle → rsp_done_o=1.
- **Abort and reset:** drop enable_i during SEND_RSP → all outputs 0 next cycle. Assert reset mid-WAIT_REQ → outputs 0 asynchronously.
- **Duplicate request (LINKINIT_RSP_DUP_EN):** after DONE, a second REQ with data 0x2 → rsp_done_o=0 and a new RSP carrying 0x2. Without the macro, the second REQ sees RX req=0 and rsp_done_o stays 1.

Source files
------------

// File: rtl/SB_codex_pkg.sv
// Sideband message codes and the LINKINIT responder state encoding,
// shared by the LINKINIT initiator/responder pair and their benches.
package SB_codex_pkg;

    typedef enum logic [4:0] {
        SB_NOP                 = 5'd0,
        SB_LINKINIT_REQ_ACTIVE = 5'd1,
        SB_LINKINIT_RSP_ACTIVE = 5'd2,
        SB_MBINIT_DONE_REQ     = 5'd3,
        SB_MBINIT_DONE_RSP     = 5'd4,
        SB_TRAINERROR_REQ      = 5'd5,
        SB_TRAINERROR_RSP      = 5'd6
    } SB_msg_t;

    typedef enum logic [2:0] {
        LIR_IDLE     = 3'd0,
        LIR_WAIT_REQ = 3'd1,
        LIR_SEND_RSP = 3'd2,
        LIR_DONE     = 3'd3,
        LIR_ERROR    = 3'd4
    } linkinit_rsp_state_t;

    localparam int unsigned SB_DATA_W = 64;
    localparam int unsigned UNEXP_W   = 4;

    function automatic logic [UNEXP_W-1:0] sat_inc(input logic [UNEXP_W-1:0] v);
        return (v == {UNEXP_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/linkinit_sb_responder.sv
// LINKINIT sideband responder: answers the partner's Req.Active with an echoed Rsp.Active.
// Outputs registered from next state; LINKINIT_RSP_DUP_EN lets DONE re-answer a retried request.
module linkinit_sb_responder
    import SB_codex_pkg::*;
#(
    parameter int unsigned MAX_UNEXPECTED = 8
) (
    input  logic                 clk_100MHz,
    input  logic                 reset,
    input  logic                 enable_i,
    output logic                 rsp_done_o,
    output logic                 rsp_error_o,
    output SB_msg_t              SB_TX_msg_o,
    output logic [SB_DATA_W-1:0] SB_TX_dataBus_o,
    output logic                 SB_TX_msg_valid_o,
    input  logic                 SB_TX_msg_sendNextFlag_i,
    input  SB_msg_t              SB_RX_msg_i,
    input  logic [SB_DATA_W-1:0] SB_RX_dataBus_i,
    output logic                 SB_RX_msg_req_o,
    input  logic                 SB_RX_msg_valid_i,
    input  logic                 SBmessage_retry_timeout_flag,
    output logic                 reset_SBmessage_retry_timeout,
    output logic                 reset_state_timeout_counter_o
);

    localparam logic [UNEXP_W-1:0] MAX_CNT = UNEXP_W'(MAX_UNEXPECTED);

    linkinit_rsp_state_t  state_q, state_d;
    logic [UNEXP_W-1:0]   unexp_cnt_q, unexp_cnt_d;
    logic [SB_DATA_W-1:0] payload_q, payload_d;

    logic                 retry_clr_d, state_clr_d;
    logic                 tx_vld_d, rx_req_d, done_d, err_d;
    SB_msg_t              tx_msg_d;
    logic [SB_DATA_W-1:0] tx_dat_d;

    logic rx_take, req_match, tx_accept;

    assign rx_take   = SB_RX_msg_valid_i & SB_RX_msg_req_o;
    assign req_match = rx_take && (SB_RX_msg_i == SB_LINKINIT_REQ_ACTIVE);
    assign tx_accept = SB_TX_msg_valid_o & SB_TX_msg_sendNextFlag_i;

    always_comb begin
        state_d     = state_q;
        unexp_cnt_d = unexp_cnt_q;
        payload_d   = payload_q;
        retry_clr_d = 1'b0;
        state_clr_d = 1'b0;

        if (!enable_i) begin
            state_d = LIR_IDLE;
        end else begin
            case (state_q)
                LIR_IDLE: begin
                    state_d     = LIR_WAIT_REQ;
                    unexp_cnt_d = '0;
                    retry_clr_d = 1'b1;
                    state_clr_d = 1'b1;
                end
                LIR_WAIT_REQ: begin
                    // A matching request beats a timeout landing in the same cycle.
                    if (req_match) begin
                        payload_d   = SB_RX_dataBus_i;
                        state_d     = LIR_SEND_RSP;
                        retry_clr_d = 1'b1;
                    end else begin
                        if (rx_take) begin
                            unexp_cnt_d = sat_inc(unexp_cnt_q);
                            if (unexp_cnt_d >= MAX_CNT) begin
                                state_d = LIR_ERROR;
                            end
                        end
                        if (SBmessage_retry_timeout_flag) begin
                            state_d = LIR_ERROR;
                        end
                    end
                end
                LIR_SEND_RSP: begin
                    if (tx_accept) begin
                        state_d = LIR_DONE;
                    end else if (SBmessage_retry_timeout_flag) begin
                        state_d = LIR_ERROR;
                    end
                end
                LIR_DONE: begin
`ifdef LINKINIT_RSP_DUP_EN
                    // Partner lost our response and retried: answer again with its new payload.
                    if (req_match) begin
                        payload_d   = SB_RX_dataBus_i;
                        state_d     = LIR_SEND_RSP;
                        retry_clr_d = 1'b1;
                    end
`endif
                end
                LIR_ERROR: begin
                    state_d = LIR_ERROR;
                end
                default: begin
                    state_d = LIR_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        tx_vld_d = (state_d == LIR_SEND_RSP);
        tx_msg_d = tx_vld_d ? SB_LINKINIT_RSP_ACTIVE : SB_NOP;
        tx_dat_d = tx_vld_d ? payload_d : '0;
        done_d   = (state_d == LIR_DONE);
        err_d    = (state_d == LIR_ERROR);
`ifdef LINKINIT_RSP_DUP_EN
        rx_req_d = (state_d == LIR_WAIT_REQ) || (state_d == LIR_DONE);
`else
        rx_req_d = (state_d == LIR_WAIT_REQ);
`endif
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q                       <= LIR_IDLE;
            unexp_cnt_q                   <= '0;
            payload_q                     <= '0;
            rsp_done_o                    <= 1'b0;
            rsp_error_o                   <= 1'b0;
            SB_TX_msg_o                   <= SB_NOP;
            SB_TX_dataBus_o               <= '0;
            SB_TX_msg_valid_o             <= 1'b0;
            SB_RX_msg_req_o               <= 1'b0;
            reset_SBmessage_retry_timeout <= 1'b0;
            reset_state_timeout_counter_o <= 1'b0;
        end else begin
            state_q                       <= state_d;
            unexp_cnt_q                   <= unexp_cnt_d;
            payload_q                     <= payload_d;
            rsp_done_o                    <= done_d;
            rsp_error_o                   <= err_d;
            SB_TX_msg_o                   <= tx_msg_d;
            SB_TX_dataBus_o               <= tx_dat_d;
            SB_TX_msg_valid_o             <= tx_vld_d;
            SB_RX_msg_req_o               <= rx_req_d;
            reset_SBmessage_retry_timeout <= retry_clr_d;
            reset_state_timeout_counter_o <= state_clr_d;
        end
    end

endmodule

// File: tb/tb_linkinit_sb_responder.sv
// Directed bench for linkinit_sb_responder (MAX_UNEXPECTED=3); inputs change and
// outputs are sampled 1ns after each rising edge.
module tb_linkinit_sb_responder;
    import SB_codex_pkg::*;

    logic          clk;
    logic          rst;
    logic          enable;
    logic          rsp_done, rsp_error;
    SB_msg_t       tx_msg;
    logic [63:0]   tx_dat;
    logic          tx_vld;
    logic          tx_next;
    SB_msg_t       rx_msg;
    logic [63:0]   rx_dat;
    logic          rx_req;
    logic          rx_vld;
    logic          tmo;
    logic          retry_clr;
    logic          state_clr;

    int checks = 0;
    int errors = 0;

    linkinit_sb_responder #(.MAX_UNEXPECTED(3)) dut (
        .clk_100MHz                    (clk),
        .reset                         (rst),
        .enable_i                      (enable),
        .rsp_done_o                    (rsp_done),
        .rsp_error_o                   (rsp_error),
        .SB_TX_msg_o                   (tx_msg),
        .SB_TX_dataBus_o               (tx_dat),
        .SB_TX_msg_valid_o             (tx_vld),
        .SB_TX_msg_sendNextFlag_i      (tx_next),
        .SB_RX_msg_i                   (rx_msg),
        .SB_RX_dataBus_i               (rx_dat),
        .SB_RX_msg_req_o               (rx_req),
        .SB_RX_msg_valid_i             (rx_vld),
        .SBmessage_retry_timeout_flag  (tmo),
        .reset_SBmessage_retry_timeout (retry_clr),
        .reset_state_timeout_counter_o (state_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_send(input SB_msg_t m, input logic [63:0] d);
        rx_msg = m;
        rx_dat = d;
        rx_vld = 1'b1;
        step();
        rx_vld = 1'b0;
        rx_msg = SB_NOP;
        rx_dat = '0;
    endtask

    task automatic abort_and_start();
        enable = 1'b0;
        step();
        enable = 1'b1;
        step();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; tx_next = 1'b0; tmo = 1'b0;
        rx_vld = 1'b0; rx_msg = SB_NOP; rx_dat = '0;
        #12;
        chk("reset_tx_vld", 64'(tx_vld), 64'd0);
        chk("reset_tx_msg", 64'(tx_msg), 64'(SB_NOP));
        chk("reset_rx_req", 64'(rx_req), 64'd0);
        chk("reset_done",   64'(rsp_done), 64'd0);
        chk("reset_error",  64'(rsp_error), 64'd0);
        chk("reset_clrs",   64'({retry_clr, state_clr}), 64'd0);
        rst = 1'b0;
        step();
        chk("idle_rx_req", 64'(rx_req), 64'd0);

        // Nominal handshake
        enable = 1'b1;
        step();
        chk("enter_rx_req",    64'(rx_req), 64'd1);
        chk("enter_retry_clr", 64'(retry_clr), 64'd1);
        chk("enter_state_clr", 64'(state_clr), 64'd1);
        step();
        chk("pulse_len", 64'({retry_clr, state_clr}), 64'd0);
        rx_send(SB_LINKINIT_REQ_ACTIVE, 64'hDEADBEEF_00000001);
        chk("rsp_vld_c1",  64'(tx_vld), 64'd1);
        chk("rsp_msg",     64'(tx_msg), 64'(SB_LINKINIT_RSP_ACTIVE));
        chk("rsp_dat",     tx_dat, 64'hDEADBEEF_00000001);
        chk("rsp_rx_req",  64'(rx_req), 64'd0);
        chk("rsp_retry_clr", 64'(retry_clr), 64'd1);
        step();
        chk("rsp_vld_c2", 64'(tx_vld), 64'd1);
        step();
        chk("rsp_vld_c3", 64'(tx_vld), 64'd1);
        chk("rsp_dat_c3", tx_dat, 64'hDEADBEEF_00000001);
        tx_next = 1'b1;
        step();
        tx_next = 1'b0;
        chk("acc_vld",  64'(tx_vld), 64'd0);
        chk("acc_done", 64'(rsp_done), 64'd1);
        step();
        chk("done_hold", 64'(rsp_done), 64'd1);

        // Retried request while DONE
`ifdef LINKINIT_RSP_DUP_EN
        chk("dup_rx_req", 64'(rx_req), 64'd1);
        rx_send(SB_LINKINIT_REQ_ACTIVE, 64'h2);
        chk("dup_done", 64'(rsp_done), 64'd0);
        chk("dup_vld",  64'(tx_vld), 64'd1);
        chk("dup_dat",  tx_dat, 64'h2);
        tx_next = 1'b1;
        step();
        tx_next = 1'b0;
        chk("dup_done2", 64'(rsp_done), 64'd1);
`else
        chk("dup_rx_req", 64'(rx_req), 64'd0);
        rx_send(SB_LINKINIT_REQ_ACTIVE, 64'h2);
        chk("dup_done", 64'(rsp_done), 64'd1);
        chk("dup_vld",  64'(tx_vld), 64'd0);
`endif

        // Unexpected flood
        abort_and_start();
        rx_send(SB_NOP, 64'h0);
        chk("flood1_err", 64'(rsp_error), 64'd0);
        rx_send(SB_MBINIT_DONE_REQ, 64'h0);
        chk("flood2_err", 64'(rsp_error), 64'd0);
        chk("flood2_req", 64'(rx_req), 64'd1);
        rx_send(SB_TRAINERROR_REQ, 64'h0);
        chk("flood3_err", 64'(rsp_error), 64'd1);
        chk("flood3_req", 64'(rx_req), 64'd0);
        rx_send(SB_LINKINIT_REQ_ACTIVE, 64'h5);
        chk("flood_req_ignored_vld", 64'(tx_vld), 64'd0);
        chk("flood_req_ignored_err", 64'(rsp_error), 64'd1);

        // Abort clears error; counter restarts from zero
        enable = 1'b0;
        step();
        chk("abort_err_clr", 64'(rsp_error), 64'd0);
        enable = 1'b1;
        step();
        rx_send(SB_NOP, 64'h0);
        rx_send(SB_NOP, 64'h0);
        chk("cnt_cleared", 64'(rsp_error), 64'd0);

        // Timeout in WAIT_REQ
        abort_and_start();
        tmo = 1'b1;
        step();
        tmo = 1'b0;
        chk("tmo_err", 64'(rsp_error), 64'd1);
        chk("tmo_req", 64'(rx_req), 64'd0);

        // Unexpected message together with timeout
        abort_and_start();
        tmo = 1'b1;
        rx_send(SB_NOP, 64'h0);
        tmo = 1'b0;
        chk("unexp_tmo_err", 64'(rsp_error), 64'd1);

        // Races: request+timeout, then accept+timeout
        abort_and_start();
        tmo = 1'b1;
        rx_send(SB_LINKINIT_REQ_ACTIVE, 64'h0123_4567_89AB_CDEF);
        chk("race1_vld", 64'(tx_vld), 64'd1);
        chk("race1_err", 64'(rsp_error), 64'd0);
        chk("race1_dat", tx_dat, 64'h0123_4567_89AB_CDEF);
        tx_next = 1'b1;
        step();
        tx_next = 1'b0;
        tmo = 1'b0;
        chk("race2_done", 64'(rsp_done), 64'd1);
        chk("race2_err",  64'(rsp_error), 64'd0);

        // Timeout while sending response
        abort_and_start();
        rx_send(SB_LINKINIT_REQ_ACTIVE, 64'h77);
        tmo = 1'b1;
        step();
        tmo = 1'b0;
        chk("send_tmo_err", 64'(rsp_error), 64'd1);
        chk("send_tmo_vld", 64'(tx_vld), 64'd0);

        // Abort during SEND_RSP
        abort_and_start();
        rx_send(SB_LINKINIT_REQ_ACTIVE, 64'hAA55);
        chk("pre_abort_vld", 64'(tx_vld), 64'd1);
        enable = 1'b0;
        tx_next = 1'b1;
        step();
        tx_next = 1'b0;
        chk("abort_vld",  64'(tx_vld), 64'd0);
        chk("abort_msg",  64'(tx_msg), 64'(SB_NOP));
        chk("abort_dat",  tx_dat, 64'd0);
        chk("abort_done", 64'(rsp_done), 64'd0);

        // Asynchronous reset in WAIT_REQ
        enable = 1'b1;
        step();
        chk("pre_rst_req", 64'(rx_req), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_req", 64'(rx_req), 64'd0);
        chk("async_rst_clr", 64'({retry_clr, state_clr}), 64'd0);
        #2 rst = 1'b0;
        #1;
        chk("post_rst_req", 64'(rx_req), 64'd0);
        step();
        chk("post_rst_edge_req", 64'(rx_req), 64'd1);
        chk("post_rst_edge_clr", 64'(state_clr), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
